// File: rtl/mig_app_responder.sv
// Simulation/hardware stand-in for the MIG 7-series app_* user interface: calibration delay,
// backpressure, a 4-entry write-data FIFO, byte-masked RAM writes and fixed-latency reads.
module mig_app_responder #(
    parameter int unsigned ADDR_WIDTH       = 28,
    parameter int unsigned APP_DATA_WIDTH   = 128,
    parameter int unsigned MEM_DEPTH_LOG2   = 8,
    parameter int unsigned RD_LATENCY       = 4,
    parameter int unsigned CALIB_CYCLES     = 64,
    parameter int unsigned RDY_STALL_PERIOD = 7
) (
    input  logic                        ui_clk_i,
    input  logic                        ui_rst_i,
    input  logic [ADDR_WIDTH-1:0]       app_addr_i,
    input  logic [2:0]                  app_cmd_i,
    input  logic                        app_en_i,
    output logic                        app_rdy_o,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data_i,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask_i,
    input  logic                        app_wdf_wren_i,
    input  logic                        app_wdf_end_i,
    output logic                        app_wdf_rdy_o,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data_o,
    output logic                        app_rd_data_valid_o,
    output logic                        app_rd_data_end_o,
    output logic                        init_calib_complete_o,
    output logic                        protocol_error_o
);
    localparam int unsigned MaskW = APP_DATA_WIDTH / 8;
    localparam int unsigned Depth = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CalW  = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
    localparam int unsigned StW   = (RDY_STALL_PERIOD > 1) ? $clog2(RDY_STALL_PERIOD) : 1;

    typedef enum logic [0:0] {StIdle, StWaitWdata} state_e;

    state_e                    state_q, state_d;
    logic [MEM_DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;
    logic [CalW-1:0]           cal_q;
    logic [StW-1:0]            stall_q;
    logic                      perr_q;
    logic [APP_DATA_WIDTH-1:0] mem_q [Depth];
    logic [APP_DATA_WIDTH-1:0] fifo_data_q [4];
    logic [MaskW-1:0]          fifo_mask_q [4];
    logic [1:0]                rp_q, wp_q;
    logic [2:0]                count_q;
    logic [RD_LATENCY-1:0]     rv_q;
    logic [APP_DATA_WIDTH-1:0] rd_q [RD_LATENCY];

    logic                      calib, stall_cycle, fifo_full, fifo_ne, cmd_fire, data_beat;
    logic                      push, pop, bypass, rd_fire, cmd_err, wr_en;
    logic [MEM_DEPTH_LOG2-1:0] cmd_idx, wr_idx;
    logic [APP_DATA_WIDTH-1:0] wr_data;
    logic [MaskW-1:0]          wr_mask;
    logic                      unused_addr;

    // Only the word index matters; other address bits alias.
    assign cmd_idx     = app_addr_i[3 +: MEM_DEPTH_LOG2];
    assign unused_addr = ^{app_addr_i[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2], app_addr_i[2:0]};

    assign calib       = (cal_q == CalW'(CALIB_CYCLES));
    assign stall_cycle = (RDY_STALL_PERIOD != 0) && (stall_q == StW'(RDY_STALL_PERIOD - 1));
    assign fifo_full   = (count_q == 3'd4);
    assign fifo_ne     = (count_q != 3'd0);

    assign app_rdy_o     = calib & ~stall_cycle & (state_q == StIdle);
    assign app_wdf_rdy_o = calib & ~fifo_full;
    assign cmd_fire      = app_en_i & app_rdy_o;
    assign data_beat     = app_wdf_wren_i & app_wdf_rdy_o;
    assign push          = data_beat & ~bypass;

    always_comb begin
        state_d    = state_q;
        pend_idx_d = pend_idx_q;
        wr_en      = 1'b0;
        wr_idx     = cmd_idx;
        wr_data    = app_wdf_data_i;
        wr_mask    = app_wdf_mask_i;
        pop        = 1'b0;
        bypass     = 1'b0;
        rd_fire    = 1'b0;
        cmd_err    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    case (app_cmd_i)
                        3'd0: begin
                            if (fifo_ne) begin
                                wr_en   = 1'b1;
                                wr_data = fifo_data_q[rp_q];
                                wr_mask = fifo_mask_q[rp_q];
                                pop     = 1'b1;
                            end else if (data_beat) begin
                                wr_en  = 1'b1;
                                bypass = 1'b1;
                            end else begin
                                state_d    = StWaitWdata;
                                pend_idx_d = cmd_idx;
                            end
                        end
                        3'd1:    rd_fire = 1'b1;
                        default: cmd_err = 1'b1;
                    endcase
                end
            end
            StWaitWdata: begin
                wr_idx = pend_idx_q;
                if (fifo_ne) begin
                    wr_en   = 1'b1;
                    wr_data = fifo_data_q[rp_q];
                    wr_mask = fifo_mask_q[rp_q];
                    pop     = 1'b1;
                    state_d = StIdle;
                end else if (data_beat) begin
                    wr_en   = 1'b1;
                    bypass  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge ui_clk_i or posedge ui_rst_i) begin
        if (ui_rst_i) begin
            state_q    <= StIdle;
            pend_idx_q <= '0;
            cal_q      <= '0;
            stall_q    <= '0;
            perr_q     <= 1'b0;
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            rv_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pend_idx_q <= pend_idx_d;
            cal_q      <= calib ? cal_q : cal_q + 1'b1;
            stall_q    <= stall_cycle ? '0 : stall_q + 1'b1;
            perr_q     <= perr_q | (app_wdf_wren_i & fifo_full) |
                          (app_wdf_wren_i ^ app_wdf_end_i) | cmd_err;
            rp_q       <= rp_q + {1'b0, pop};
            wp_q       <= wp_q + {1'b0, push};
            count_q    <= count_q + {2'b0, push} - {2'b0, pop};
            rv_q       <= {rv_q[RD_LATENCY-2:0], rd_fire};
            // Idle stages carry zeros so the output bus is 0 whenever not valid.
            rd_q[0]    <= rd_fire ? mem_q[cmd_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) rd_q[i] <= rd_q[i-1];
        end
    end

    // Storage without reset: RAM contents survive ui_rst.
    always_ff @(posedge ui_clk_i) begin
        if (push) begin
            fifo_data_q[wp_q] <= app_wdf_data_i;
            fifo_mask_q[wp_q] <= app_wdf_mask_i;
        end
        if (wr_en) begin
            for (int b = 0; b < MaskW; b++) begin
                if (!wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign app_rd_data_o         = rd_q[RD_LATENCY-1];
    assign app_rd_data_valid_o   = rv_q[RD_LATENCY-1];
    assign app_rd_data_end_o     = rv_q[RD_LATENCY-1];
    assign init_calib_complete_o = calib;
    assign protocol_error_o      = perr_q;

endmodule
